music_req_sched: RTL and testbench



---
 rtl/music_pkg.sv | 52 +++++
 rtl/req_edge_det.sv | 37 +++
 rtl/music_req_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_music_req_sched.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared command codes, source indices and state encoding for the voice/music
// request scheduler.
package music_pkg;

    localparam int unsigned NumSrc = 5;
    localparam int unsigned SrcW   = 3;
    localparam int unsigned TimerW = 28;

    // Source index doubles as priority: lower index wins.
    localparam logic [SrcW-1:0] SrcGy      = 3'd0;
    localparam logic [SrcW-1:0] SrcTuAo    = 3'd1;
    localparam logic [SrcW-1:0] SrcZhiwen  = 3'd2;
    localparam logic [SrcW-1:0] SrcShijian = 3'd3;
    localparam logic [SrcW-1:0] SrcMusic   = 3'd4;

    localparam logic [7:0] CodeTilt    = 8'h01;
    localparam logic [7:0] CodeFall    = 8'h02;
    localparam logic [7:0] CodeBump    = 8'h03;
    localparam logic [7:0] CodePit     = 8'h04;
    localparam logic [7:0] CodeMatch   = 8'h05;
    localparam logic [7:0] CodeReject  = 8'h06;
    localparam logic [7:0] CodeShijian = 8'h10;
    localparam logic [7:0] CodeMusic   = 8'h20;
    localparam logic [7:0] CodeStop    = 8'h7F;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitTx,
        StWaitPlay,
        StStop,
        StGap
    } sched_state_e;

    function automatic logic [SrcW-1:0] pick_src(input logic [NumSrc-1:0] elig);
        logic [SrcW-1:0] win;
        win = SrcMusic;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = SrcW'(i);
            end
        end
        return win;
    endfunction

    function automatic logic [7:0] flag_code(input logic [1:0] val,
                                             input logic [7:0] code_01,
                                             input logic [7:0] code_10);
        return (val == 2'b01) ? code_01 : code_10;
    endfunction

endpackage

// File: rtl/req_edge_det.sv
// Per-source event detector: compares each flag against its previous value and
// captures the flag value that caused the most recent event.
module req_edge_det #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] flag_i,
    output logic             evt_o,
    output logic [Width-1:0] val_o
);

    logic [Width-1:0] prev_q;
    logic [Width-1:0] val_q;

    // prev_q tracks the flag through reset so an already-active flag is not an event.
    always_ff @(posedge clk_i) begin
        prev_q <= flag_i;
        if (rst_i) begin
            val_q <= '0;
        end else if (evt_o) begin
            val_q <= flag_i;
        end
    end

    generate
        if (Width == 1) begin : g_level
            assign evt_o = flag_i[0] & ~prev_q[0];
        end else begin : g_code
            assign evt_o = (flag_i != prev_q) &&
                           ((flag_i == Width'(1)) || (flag_i == Width'(2)));
        end
    endgenerate

    assign val_o = val_q;

endmodule

// File: rtl/music_req_sched.sv
// Fixed-priority scheduler that sequences announcement and song requests into the
// UART voice-module framer, letting safety alerts preempt a playing song.
module music_req_sched
    import music_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 250_000_000,
    parameter int unsigned GAP_CYC     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] flag_GY25,
    input  logic [1:0] flag_tu_ao,
    input  logic [1:0] flag_zhiwen,
    input  logic       flag_shijian,
    input  logic       flag_music,
    input  logic       sj_en,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    input  logic       cmd_ready,
    input  logic       tx_done,
    input  logic       play_done,
    output logic       busy,
    output logic       over_all,
    output logic       err_timeout
);

    localparam logic [TimerW-1:0] TimeoutLast =
        (TIMEOUT_CYC > 0) ? TimerW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [TimerW-1:0] GapLast =
        (GAP_CYC > 0) ? TimerW'(GAP_CYC - 1) : '0;

    logic [NumSrc-1:0] evt;
    logic [1:0]        gy_val;
    logic [1:0]        tu_val;
    logic [1:0]        zh_val;
    logic              sj_val;
    logic              mu_val;
    logic              unused_vals;

    req_edge_det #(.Width(2)) u_det_gy (
        .clk_i  (clk),
        .rst_i  (rst),
        .flag_i (flag_GY25),
        .evt_o  (evt[SrcGy]),
        .val_o  (gy_val)
    );

    req_edge_det #(.Width(2)) u_det_tu (
        .clk_i  (clk),
        .rst_i  (rst),
        .flag_i (flag_tu_ao),
        .evt_o  (evt[SrcTuAo]),
        .val_o  (tu_val)
    );

    req_edge_det #(.Width(2)) u_det_zh (
        .clk_i  (clk),
        .rst_i  (rst),
        .flag_i (flag_zhiwen),
        .evt_o  (evt[SrcZhiwen]),
        .val_o  (zh_val)
    );

    req_edge_det #(.Width(1)) u_det_sj (
        .clk_i  (clk),
        .rst_i  (rst),
        .flag_i (flag_shijian),
        .evt_o  (evt[SrcShijian]),
        .val_o  (sj_val)
    );

    req_edge_det #(.Width(1)) u_det_mu (
        .clk_i  (clk),
        .rst_i  (rst),
        .flag_i (flag_music),
        .evt_o  (evt[SrcMusic]),
        .val_o  (mu_val)
    );

    // Level sources carry a fixed code; their captured value adds nothing.
    assign unused_vals = sj_val ^ mu_val;

    logic [7:0] src_code [NumSrc];

    assign src_code[SrcGy]      = flag_code(gy_val, CodeTilt, CodeFall);
    assign src_code[SrcTuAo]    = flag_code(tu_val, CodeBump, CodePit);
    assign src_code[SrcZhiwen]  = flag_code(zh_val, CodeMatch, CodeReject);
    assign src_code[SrcShijian] = CodeShijian;
    assign src_code[SrcMusic]   = CodeMusic;

    sched_state_e      state_q;
    logic [NumSrc-1:0] pending_q;
    logic [NumSrc-1:0] pending_d;
    logic [SrcW-1:0]   cur_src_q;
    logic [7:0]        cur_code_q;
    logic [TimerW-1:0] timer_q;
    logic [TimerW-1:0] timer_inc;
    logic              stop_acc_q;
    logic              cmd_valid_q;
    logic [7:0]        cmd_code_q;
    logic              over_all_q;
    logic              err_timeout_q;

    logic [NumSrc-1:0] elig;
    logic [SrcW-1:0]   win_src;
    logic [7:0]        win_code;
    logic              issue_acc;
    logic              preempt;

    // A time announcement is held back until its digits are valid.
    assign elig      = pending_q & {1'b1, sj_en, 3'b111};
    assign win_src   = pick_src(elig);
    assign win_code  = src_code[win_src];
    assign issue_acc = (state_q == StIssue) && cmd_valid_q && cmd_ready;
    assign preempt   = (cur_code_q == CodeMusic) && (|pending_q[SrcZhiwen:SrcGy]);
    assign timer_inc = (&timer_q) ? timer_q : timer_q + TimerW'(1);

    // A fresh event in the accept cycle re-arms the source rather than being lost.
    always_comb begin
        pending_d = pending_q;
        if (issue_acc) begin
            pending_d[cur_src_q] = 1'b0;
        end
        pending_d = pending_d | evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cur_src_q     <= '0;
            cur_code_q    <= '0;
            timer_q       <= '0;
            stop_acc_q    <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= '0;
            over_all_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            over_all_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|elig) begin
                        cur_src_q   <= win_src;
                        cur_code_q  <= win_code;
                        cmd_code_q  <= win_code;
                        cmd_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (issue_acc) begin
                        cmd_valid_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= StWaitTx;
                    end
                end
                StWaitTx: begin
                    if (tx_done) begin
                        timer_q <= '0;
                        state_q <= StWaitPlay;
                    end else if (timer_q >= TimeoutLast) begin
                        err_timeout_q <= 1'b1;
                        timer_q       <= '0;
                        state_q       <= StGap;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StWaitPlay: begin
                    // Completion beats a coincident timeout, which beats preemption.
                    if (play_done) begin
                        over_all_q <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= StGap;
                    end else if (timer_q >= TimeoutLast) begin
                        err_timeout_q <= 1'b1;
                        timer_q       <= '0;
                        state_q       <= StGap;
                    end else if (preempt) begin
                        cmd_valid_q <= 1'b1;
                        cmd_code_q  <= CodeStop;
                        stop_acc_q  <= 1'b0;
                        state_q     <= StStop;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StStop: begin
                    if (!stop_acc_q) begin
                        if (cmd_ready) begin
                            cmd_valid_q <= 1'b0;
                            stop_acc_q  <= 1'b1;
                        end
                    end else if (tx_done) begin
                        timer_q <= '0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (timer_q >= GapLast) begin
                        timer_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign busy        = (state_q != StIdle);
    assign over_all    = over_all_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_music_req_sched.sv
// Directed bench for music_req_sched with a cycle-level behavioural model checked
// against the DUT outputs on every falling edge.
module tb_music_req_sched;

    localparam int TimeoutCyc = 40;
    localparam int GapCyc     = 8;

    localparam int PhIdle  = 0;
    localparam int PhIssue = 1;
    localparam int PhTx    = 2;
    localparam int PhPlay  = 3;
    localparam int PhStop  = 4;
    localparam int PhGap   = 5;

    logic       clk;
    logic       rst;
    logic [1:0] flag_GY25;
    logic [1:0] flag_tu_ao;
    logic [1:0] flag_zhiwen;
    logic       flag_shijian;
    logic       flag_music;
    logic       sj_en;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       cmd_ready;
    logic       tx_done;
    logic       play_done;
    logic       busy;
    logic       over_all;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    music_req_sched #(
        .TIMEOUT_CYC (TimeoutCyc),
        .GAP_CYC     (GapCyc)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flag_GY25    (flag_GY25),
        .flag_tu_ao   (flag_tu_ao),
        .flag_zhiwen  (flag_zhiwen),
        .flag_shijian (flag_shijian),
        .flag_music   (flag_music),
        .sj_en        (sj_en),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .cmd_ready    (cmd_ready),
        .tx_done      (tx_done),
        .play_done    (play_done),
        .busy         (busy),
        .over_all     (over_all),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, want %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-source pending/code arrays and a phase with a cycle count.
    int         m_prev [5];
    bit         m_pend [5];
    logic [7:0] m_code [5];
    int         m_phase = PhIdle;
    int         m_cnt = 0;
    int         m_cur = 0;
    logic [7:0] m_cur_code = 8'h00;
    bit         m_stop_acc = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_code = 8'h00;
    logic       exp_busy = 1'b0;
    logic       exp_over = 1'b0;
    logic       exp_err = 1'b0;

    task automatic model_step();
        int f [5];
        bit ev [5];
        bit acc;
        int win;
        f[0] = int'(flag_GY25);
        f[1] = int'(flag_tu_ao);
        f[2] = int'(flag_zhiwen);
        f[3] = int'(flag_shijian);
        f[4] = int'(flag_music);
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                m_prev[i] = f[i];
                m_pend[i] = 0;
            end
            m_phase   = PhIdle;
            m_cnt     = 0;
            exp_valid = 1'b0;
            exp_code  = 8'h00;
            exp_over  = 1'b0;
            exp_err   = 1'b0;
            exp_busy  = 1'b0;
            return;
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 3) ev[i] = (f[i] != m_prev[i]) && (f[i] == 1 || f[i] == 2);
            else       ev[i] = (f[i] == 1) && (m_prev[i] == 0);
        end
        exp_over = 1'b0;
        exp_err  = 1'b0;
        acc      = 0;
        case (m_phase)
            PhIdle: begin
                win = -1;
                for (int i = 0; i < 5; i++) begin
                    if (win < 0 && m_pend[i] && (i != 3 || sj_en)) win = i;
                end
                if (win >= 0) begin
                    m_cur      = win;
                    m_cur_code = m_code[win];
                    exp_valid  = 1'b1;
                    exp_code   = m_code[win];
                    m_phase    = PhIssue;
                end
            end
            PhIssue: begin
                if (cmd_ready) begin
                    acc       = 1;
                    exp_valid = 1'b0;
                    m_phase   = PhTx;
                    m_cnt     = 0;
                end
            end
            PhTx: begin
                if (tx_done) begin
                    m_phase = PhPlay;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt >= TimeoutCyc) begin
                        exp_err = 1'b1;
                        m_phase = PhGap;
                        m_cnt   = 0;
                    end
                end
            end
            PhPlay: begin
                m_cnt++;
                if (play_done) begin
                    exp_over = 1'b1;
                    m_phase  = PhGap;
                    m_cnt    = 0;
                end else if (m_cnt >= TimeoutCyc) begin
                    exp_err = 1'b1;
                    m_phase = PhGap;
                    m_cnt   = 0;
                end else if (m_cur_code == 8'h20 && (m_pend[0] || m_pend[1] || m_pend[2])) begin
                    exp_valid  = 1'b1;
                    exp_code   = 8'h7F;
                    m_stop_acc = 0;
                    m_phase    = PhStop;
                end
            end
            PhStop: begin
                if (!m_stop_acc) begin
                    if (cmd_ready) begin
                        exp_valid  = 1'b0;
                        m_stop_acc = 1;
                    end
                end else if (tx_done) begin
                    m_phase = PhGap;
                    m_cnt   = 0;
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt >= GapCyc) begin
                    m_phase = PhIdle;
                    m_cnt   = 0;
                end
            end
        endcase
        if (acc) m_pend[m_cur] = 0;
        for (int i = 0; i < 5; i++) begin
            if (ev[i]) begin
                m_pend[i] = 1;
                if (i < 3)       m_code[i] = 8'(2 * i + f[i]);
                else if (i == 3) m_code[i] = 8'h10;
                else             m_code[i] = 8'h20;
            end
            m_prev[i] = f[i];
        end
        exp_busy = (m_phase != PhIdle);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("cyc cmd_valid", cmd_valid, exp_valid);
                chk8("cyc cmd_code", cmd_code, exp_code);
                chk1("cyc busy", busy, exp_busy);
                chk1("cyc over_all", over_all, exp_over);
                chk1("cyc err_timeout", err_timeout, exp_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_valid === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk1({name, " offered"}, seen, 1'b1);
    endtask

    task automatic issue_accept(input logic [7:0] code, input string name);
        wait_valid(100, name);
        chk8({name, " code"}, cmd_code, code);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk1({name, " valid drops"}, cmd_valid, 1'b0);
    endtask

    task automatic pulse_tx();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic pulse_play(input logic exp_ov, input string name);
        play_done = 1'b1;
        tick();
        play_done = 1'b0;
        chk1({name, " over_all"}, over_all, exp_ov);
    endtask

    task automatic finish_cmd(input string name);
        tick();
        pulse_tx();
        tick();
        pulse_play(1'b1, name);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        flag_GY25    = 2'b10;
        flag_tu_ao   = 2'b00;
        flag_zhiwen  = 2'b00;
        flag_shijian = 1'b0;
        flag_music   = 1'b0;
        sj_en        = 1'b0;
        cmd_ready    = 1'b0;
        tx_done      = 1'b0;
        play_done    = 1'b0;
        repeat (3) tick();
        chk_en = 1;
        chk1("reset cmd_valid", cmd_valid, 1'b0);
        chk8("reset cmd_code", cmd_code, 8'h00);
        chk1("reset busy", busy, 1'b0);
        rst = 1'b0;

        // Fall flag held through reset must not raise a request.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("held flag no cmd", cmd_valid, 1'b0);
        end

        // 10 -> 00 -> 10 gives fall; cmd_valid appears on the second edge.
        flag_GY25 = 2'b00;
        tick();
        tick();
        flag_GY25 = 2'b10;
        tick();
        chk1("fall latency edge1", cmd_valid, 1'b0);
        tick();
        chk1("fall latency edge2", cmd_valid, 1'b1);
        chk8("fall code", cmd_code, 8'h02);
        chk1("busy while issuing", busy, 1'b1);
        issue_accept(8'h02, "fall");
        finish_cmd("fall");

        // Simultaneous bump and reject: bump first; a match arriving on the
        // reject accept re-arms the fingerprint source with the new code.
        flag_tu_ao  = 2'b01;
        flag_zhiwen = 2'b10;
        issue_accept(8'h03, "bump");
        finish_cmd("bump");
        wait_valid(100, "reject");
        chk8("reject code", cmd_code, 8'h06);
        cmd_ready   = 1'b1;
        flag_zhiwen = 2'b01;
        tick();
        cmd_ready = 1'b0;
        finish_cmd("reject");
        issue_accept(8'h05, "match");
        finish_cmd("match");
        flag_tu_ao  = 2'b00;
        flag_zhiwen = 2'b00;

        // Time request with sj_en low waits; the song goes first.
        flag_shijian = 1'b1;
        flag_music   = 1'b1;
        tick();
        flag_shijian = 1'b0;
        issue_accept(8'h20, "song1");
        tick();
        pulse_tx();
        sj_en = 1'b1;
        repeat (3) tick();
        chk1("time does not preempt song", cmd_valid, 1'b0);
        pulse_play(1'b1, "song1");
        issue_accept(8'h10, "time");
        finish_cmd("time");

        // Tilt during song playback forces a stop, then the tilt itself.
        flag_music = 1'b0;
        tick();
        flag_music = 1'b1;
        issue_accept(8'h20, "song2");
        tick();
        pulse_tx();
        repeat (2) tick();
        flag_GY25 = 2'b01;
        issue_accept(8'h7F, "stop");
        chk1("no over_all on preempt", over_all, 1'b0);
        tick();
        pulse_tx();
        pulse_play(1'b0, "stray play_done in gap");
        issue_accept(8'h01, "tilt");
        finish_cmd("tilt");

        // Song with no play report times out after exactly TimeoutCyc cycles.
        flag_music = 1'b0;
        tick();
        flag_music = 1'b1;
        issue_accept(8'h20, "song3");
        tick();
        pulse_tx();
        n = 0;
        while (err_timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk32("timeout latency", n, TimeoutCyc);
        tick();
        chk1("timeout single pulse", err_timeout, 1'b0);
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk1("idle after timeout", busy, 1'b0);

        // Stalled framer: offer stays stable, then reset mid-playback.
        flag_tu_ao = 2'b10;
        wait_valid(20, "pit");
        for (int i = 0; i < 100; i++) begin
            tick();
            chk1("stall valid", cmd_valid, 1'b1);
            chk8("stall code", cmd_code, 8'h04);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        pulse_tx();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk1("mid reset cmd_valid", cmd_valid, 1'b0);
        chk8("mid reset cmd_code", cmd_code, 8'h00);
        chk1("mid reset busy", busy, 1'b0);
        chk1("mid reset over_all", over_all, 1'b0);
        chk1("mid reset err_timeout", err_timeout, 1'b0);
        rst = 1'b0;
        repeat (3) tick();
        chk1("post reset idle", busy, 1'b0);
        chk1("post reset no cmd", cmd_valid, 1'b0);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
